// File: rtl/fsm3_seq_driver.sv
// fsm3_seq_driver: initiator for the 2-bit i1/i2 handshake of the IDLE/S1/S2/ER control FSM.
// Accepts "go to state T, then hold D cycles" commands and walks the consumer there along the
// shortest legal path. A shadow copy of the consumer state is kept so that the consumer's
// registered outputs can be checked on every edge.
//
// Ports
//   clk, rst           clock (rising edge) and async active-high reset
//   cmd_valid/ready    command handshake; cmd_target (2b) and cmd_dwell (DW_W) sampled on accept
//   chk_en, clr_mis    enable output checking / clear the mismatch flag and counter
//   o1, o2, err        consumer registered outputs
//   i1, i2             registered drive to the consumer
//   busy, done         command in progress / one-cycle completion pulse
//   shadow_state       modelled consumer state (same encoding as cmd_target)
//   mismatch, mis_cnt  sticky mismatch flag and saturating mismatch count
module fsm3_seq_driver #(
    parameter int unsigned DW_W  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_target,
    input  logic [DW_W-1:0]  cmd_dwell,
    input  logic             chk_en,
    input  logic             clr_mis,
    input  logic             o1,
    input  logic             o2,
    input  logic             err,
    output logic             i1,
    output logic             i2,
    output logic             busy,
    output logic             done,
    output logic [1:0]       shadow_state,
    output logic             mismatch,
    output logic [CNT_W-1:0] mis_cnt
);

    // Consumer state encoding (shared with cmd_target / shadow_state)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_S1   = 2'd1;
    localparam logic [1:0] ST_S2   = 2'd2;
    localparam logic [1:0] ST_ER   = 2'd3;

    // Driver FSM encoding
    localparam logic [1:0] FSM_READY = 2'd0;
    localparam logic [1:0] FSM_MOVE  = 2'd1;
    localparam logic [1:0] FSM_DWELL = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Consumer next-state as a function of its state and the {i1,i2} it sees
    function automatic logic [1:0] f_sh_nx(input logic [1:0] s, input logic a, input logic b);
        logic [1:0] n;
        case (s)
            ST_IDLE: n = !a ? ST_IDLE : (b ? ST_S1 : ST_ER);
            ST_S1:   n = !b ? ST_S1   : (a ? ST_S2 : ST_ER);
            ST_S2:   n =  b ? ST_S2   : (a ? ST_IDLE : ST_ER);
            default: n =  a ? ST_ER   : ST_IDLE;
        endcase
        return n;
    endfunction

    // {i1,i2} that keeps the consumer where it is
    function automatic logic [1:0] f_hold(input logic [1:0] s);
        logic [1:0] v;
        case (s)
            ST_S2:   v = 2'b01;
            ST_ER:   v = 2'b10;
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    // {i1,i2} for the first hop from s toward t (only used when s != t)
    function automatic logic [1:0] f_step(input logic [1:0] s, input logic [1:0] t);
        logic [1:0] v;
        case (s)
            ST_IDLE: v = (t == ST_ER) ? 2'b10 : 2'b11;
            ST_S1:   v = (t == ST_ER) ? 2'b01 : 2'b11;
            ST_S2:   v = (t == ST_ER) ? 2'b00 : 2'b10;
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    // Expected consumer outputs {o1,o2,err} per state
    function automatic logic [2:0] f_exp(input logic [1:0] s);
        logic [2:0] v;
        case (s)
            ST_IDLE: v = 3'b000;
            ST_S1:   v = 3'b100;
            ST_S2:   v = 3'b010;
            default: v = 3'b111;
        endcase
        return v;
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       r_shadow;
    logic [1:0]       r_target;
    logic [DW_W-1:0]  r_cnt;
    logic             r_i1;
    logic             r_i2;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_mis_cnt;

    logic [1:0]       w_state_nx;
    logic [1:0]       w_target_nx;
    logic [DW_W-1:0]  w_cnt_nx;
    logic             w_done_nx;
    logic [1:0]       w_sh_nx;
    logic             w_accept;
    logic [1:0]       w_tgt;
    logic             w_drive;
    logic [1:0]       w_ii_nx;
    logic             w_miss;
    logic             w_mismatch_nx;
    logic [CNT_W-1:0] w_mis_cnt_nx;

    // Drive path: look one edge ahead so the new {i1,i2} matches the state the consumer enters
    always_comb begin
        w_sh_nx  = f_sh_nx(r_shadow, r_i1, r_i2);
        w_accept = (r_state == FSM_READY) && cmd_valid;
        w_tgt    = w_accept ? cmd_target : r_target;
        w_drive  = (r_state == FSM_MOVE) || w_accept;
        w_ii_nx  = (w_drive && (w_sh_nx != w_tgt)) ? f_step(w_sh_nx, w_tgt) : f_hold(w_sh_nx);
    end

    // Driver FSM next state; the dwell count is latched at accept and consumed in DWELL
    always_comb begin
        w_state_nx  = r_state;
        w_target_nx = r_target;
        w_cnt_nx    = r_cnt;
        w_done_nx   = 1'b0;
        case (r_state)
            FSM_READY: begin
                if (cmd_valid) begin
                    w_state_nx  = FSM_MOVE;
                    w_target_nx = cmd_target;
                    w_cnt_nx    = cmd_dwell;
                end
            end
            FSM_MOVE: begin
                if (r_shadow == r_target) begin
                    w_state_nx = FSM_DWELL;
                end
            end
            FSM_DWELL: begin
                if (r_cnt == '0) begin
                    w_state_nx = FSM_READY;
                    w_done_nx  = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - DW_W'(1);
                end
            end
            default: w_state_nx = FSM_READY;
        endcase
    end

    // Output checker; a fresh mismatch in the clear cycle restarts the count at one
    always_comb begin
        w_miss        = ({o1, o2, err} != f_exp(r_shadow));
        w_mismatch_nx = r_mismatch;
        w_mis_cnt_nx  = r_mis_cnt;
        if (clr_mis) begin
            w_mismatch_nx = 1'b0;
            w_mis_cnt_nx  = '0;
        end
        if (chk_en && w_miss) begin
            w_mismatch_nx = 1'b1;
            if (clr_mis) begin
                w_mis_cnt_nx = CNT_W'(1);
            end else begin
                w_mis_cnt_nx = (r_mis_cnt == CNT_MAX) ? CNT_MAX : r_mis_cnt + CNT_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FSM_READY;
            r_shadow   <= ST_IDLE;
            r_target   <= ST_IDLE;
            r_cnt      <= '0;
            r_i1       <= 1'b0;
            r_i2       <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_mis_cnt  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_shadow   <= w_sh_nx;
            r_target   <= w_target_nx;
            r_cnt      <= w_cnt_nx;
            r_i1       <= w_ii_nx[1];
            r_i2       <= w_ii_nx[0];
            r_ready    <= (w_state_nx == FSM_READY);
            r_busy     <= (w_state_nx != FSM_READY);
            r_done     <= w_done_nx;
            r_mismatch <= w_mismatch_nx;
            r_mis_cnt  <= w_mis_cnt_nx;
        end
    end

    assign cmd_ready    = r_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign i1           = r_i1;
    assign i2           = r_i2;
    assign shadow_state = r_shadow;
    assign mismatch     = r_mismatch;
    assign mis_cnt      = r_mis_cnt;

endmodule

// File: tb/tb_fsm3_seq_driver.sv
// Bench for fsm3_seq_driver: a behavioural consumer closes the loop on instance A;
// instance B (CNT_W=2) has its consumer outputs driven directly for counter saturation.
module tb_fsm3_seq_driver;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    // Instance A
    logic       cmd_valid, cmd_ready, chk_en, clr_mis;
    logic [1:0] cmd_target;
    logic [3:0] cmd_dwell;
    logic       o1, o2, err, i1, i2, busy, done, mismatch;
    logic [1:0] shadow_state;
    logic [7:0] mis_cnt;

    // Instance B
    logic       cmd_valid_b, cmd_ready_b, chk_en_b, clr_mis_b;
    logic [1:0] cmd_target_b;
    logic [3:0] cmd_dwell_b;
    logic       o1_b, o2_b, err_b, i1_b, i2_b, busy_b, done_b, mismatch_b;
    logic [1:0] shadow_state_b;
    logic [1:0] mis_cnt_b;

    int n_chk = 0;
    int n_err = 0;

    logic [1:0] exp_ii_q[$];
    logic [1:0] exp_sh_q[$];
    int         exp_done_q[$];

    fsm3_seq_driver #(.DW_W(4), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_dwell(cmd_dwell), .chk_en(chk_en), .clr_mis(clr_mis),
        .o1(o1), .o2(o2), .err(err), .i1(i1), .i2(i2), .busy(busy), .done(done),
        .shadow_state(shadow_state), .mismatch(mismatch), .mis_cnt(mis_cnt)
    );

    fsm3_seq_driver #(.DW_W(4), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_target(cmd_target_b), .cmd_dwell(cmd_dwell_b), .chk_en(chk_en_b), .clr_mis(clr_mis_b),
        .o1(o1_b), .o2(o2_b), .err(err_b), .i1(i1_b), .i2(i2_b), .busy(busy_b), .done(done_b),
        .shadow_state(shadow_state_b), .mismatch(mismatch_b), .mis_cnt(mis_cnt_b)
    );

    // Behavioural consumer for instance A, with an injectable o1-stuck-low fault
    logic [1:0] c_state;
    logic       flt_o1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) c_state <= 2'd0;
        else begin
            case (c_state)
                2'd0: c_state <= !i1 ? 2'd0 : (i2 ? 2'd1 : 2'd3);
                2'd1: c_state <= !i2 ? 2'd1 : (i1 ? 2'd2 : 2'd3);
                2'd2: c_state <=  i2 ? 2'd2 : (i1 ? 2'd0 : 2'd3);
                default: c_state <= i1 ? 2'd3 : 2'd0;
            endcase
        end
    end
    assign o1  = ((c_state == 2'd1) || (c_state == 2'd3)) && !flt_o1;
    assign o2  = (c_state == 2'd2) || (c_state == 2'd3);
    assign err = (c_state == 2'd3);

    // Issue one command on A and score i1/i2, shadow and done latency against the queues
    task automatic run_cmd(input logic [1:0] t, input logic [3:0] d, input bit spam, input string nm);
        int  w;
        bit  got;
        logic [1:0] e;
        int  ed;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        n_chk++;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL %s ready_wait: got %b exp 1", nm, cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_target = t; cmd_dwell = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_target = ~t; cmd_dwell = 4'hF;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (spam) begin cmd_valid = (k == 1 || k == 2); cmd_target = 2'd0; end
            if (exp_ii_q.size() > 0) begin
                e = exp_ii_q.pop_front(); n_chk++;
                if ({i1, i2} !== e) begin n_err++; $display("FAIL %s ii[%0d]: got %b exp %b", nm, k, {i1, i2}, e); end
            end
            if (exp_sh_q.size() > 0) begin
                e = exp_sh_q.pop_front(); n_chk++;
                if (shadow_state !== e) begin n_err++; $display("FAIL %s shadow[%0d]: got %0d exp %0d", nm, k, shadow_state, e); end
            end
            if (k == 0) begin
                n_chk++;
                if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL %s busy_after_accept: got busy=%b ready=%b exp 1/0", nm, busy, cmd_ready); end
            end
            if (done === 1'b1) begin
                got = 1'b1;
                ed = (exp_done_q.size() > 0) ? exp_done_q.pop_front() : -1;
                n_chk++;
                if (k != ed) begin n_err++; $display("FAIL %s done_latency: got %0d exp %0d", nm, k, ed); end
                n_chk++;
                if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL %s ready_at_done: got ready=%b busy=%b exp 1/0", nm, cmd_ready, busy); end
            end else begin
                @(posedge clk); #1;
            end
        end
        cmd_valid = 1'b0;
        if (!got) begin n_chk++; n_err++; $display("FAIL %s done_timeout: got none exp pulse", nm); end
        @(posedge clk); #1;
        n_chk++;
        if (done !== 1'b0) begin n_err++; $display("FAIL %s done_pulse_width: got %b exp 0", nm, done); end
        exp_ii_q.delete(); exp_sh_q.delete(); exp_done_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; #2;
        n_chk++;
        if ({i1, i2, shadow_state, cmd_ready, busy, done, mismatch} !== 8'b0000_1000 || mis_cnt !== 8'd0) begin
            n_err++; $display("FAIL reset_a: got i=%b%b sh=%0d rdy=%b busy=%b done=%b mis=%b cnt=%0d exp 00/0/1/0/0/0/0",
                i1, i2, shadow_state, cmd_ready, busy, done, mismatch, mis_cnt);
        end
        n_chk++;
        if ({i1_b, i2_b, shadow_state_b, cmd_ready_b, done_b, mismatch_b, mis_cnt_b} !== 9'b00_00_1_0_0_00) begin
            n_err++; $display("FAIL reset_b: got sh=%0d rdy=%b mis=%b cnt=%0d exp 0/1/0/0", shadow_state_b, cmd_ready_b, mismatch_b, mis_cnt_b);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_idle_to_s2();
        exp_ii_q   = '{2'b11, 2'b11, 2'b01};
        exp_sh_q   = '{2'd0, 2'd1, 2'd2};
        exp_done_q = '{4};
        run_cmd(2'd2, 4'd0, 1'b0, "idle_to_s2");
        n_chk++;
        if (mismatch !== 1'b0 || mis_cnt !== 8'd0) begin n_err++; $display("FAIL idle_to_s2_chk: got mis=%b cnt=%0d exp 0/0", mismatch, mis_cnt); end
    endtask

    // Also fires cmd_valid with another target while busy; it must be ignored
    task automatic test_s2_to_er_busy();
        exp_ii_q   = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        exp_sh_q   = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        exp_done_q = '{6};
        run_cmd(2'd3, 4'd3, 1'b1, "s2_to_er");
        n_chk++;
        if (shadow_state !== 2'd3 || err !== 1'b1 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL s2_to_er_final: got sh=%0d err=%b rdy=%b exp 3/1/1", shadow_state, err, cmd_ready);
        end
        n_chk++;
        if (mismatch !== 1'b0) begin n_err++; $display("FAIL s2_to_er_chk: got mis=%b exp 0", mismatch); end
    endtask

    task automatic test_er_to_s1();
        exp_ii_q   = '{2'b00, 2'b11, 2'b00};
        exp_sh_q   = '{2'd3, 2'd0, 2'd1};
        exp_done_q = '{4};
        run_cmd(2'd1, 4'd0, 1'b0, "er_to_s1");
        n_chk++;
        if ({o1, o2, err} !== 3'b100 || mismatch !== 1'b0 || mis_cnt !== 8'd0) begin
            n_err++; $display("FAIL er_to_s1_chk: got o=%b mis=%b cnt=%0d exp 100/0/0", {o1, o2, err}, mismatch, mis_cnt);
        end
    endtask

    task automatic test_same_target();
        exp_ii_q   = '{2'b00, 2'b00, 2'b00};
        exp_sh_q   = '{2'd1, 2'd1, 2'd1};
        exp_done_q = '{4};
        run_cmd(2'd1, 4'd2, 1'b0, "same_target");
    endtask

    task automatic test_fault_count();
        @(negedge clk); flt_o1 = 1'b1;
        repeat (3) @(negedge clk);
        flt_o1 = 1'b0;
        n_chk++;
        if (mismatch !== 1'b1 || mis_cnt !== 8'd3) begin n_err++; $display("FAIL fault_count: got mis=%b cnt=%0d exp 1/3", mismatch, mis_cnt); end
        repeat (2) @(negedge clk);
        n_chk++;
        if (mis_cnt !== 8'd3) begin n_err++; $display("FAIL fault_hold: got cnt=%0d exp 3", mis_cnt); end
        chk_en = 1'b0; flt_o1 = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (mismatch !== 1'b1 || mis_cnt !== 8'd3) begin n_err++; $display("FAIL chk_disabled: got mis=%b cnt=%0d exp 1/3", mismatch, mis_cnt); end
        chk_en = 1'b1; flt_o1 = 1'b0; clr_mis = 1'b1;
        @(negedge clk); clr_mis = 1'b0;
        n_chk++;
        if (mismatch !== 1'b0 || mis_cnt !== 8'd0) begin n_err++; $display("FAIL clr_mis: got mis=%b cnt=%0d exp 0/0", mismatch, mis_cnt); end
    endtask

    task automatic test_saturation();
        @(negedge clk); o1_b = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (mis_cnt_b !== 2'd2) begin n_err++; $display("FAIL sat_mid: got cnt=%0d exp 2", mis_cnt_b); end
        repeat (4) @(negedge clk);
        n_chk++;
        if (mis_cnt_b !== 2'd3 || mismatch_b !== 1'b1) begin n_err++; $display("FAIL sat_top: got cnt=%0d mis=%b exp 3/1", mis_cnt_b, mismatch_b); end
        clr_mis_b = 1'b1;
        @(negedge clk); clr_mis_b = 1'b0; o1_b = 1'b0;
        n_chk++;
        if (mis_cnt_b !== 2'd1 || mismatch_b !== 1'b1) begin n_err++; $display("FAIL clr_vs_fault: got cnt=%0d mis=%b exp 1/1", mis_cnt_b, mismatch_b); end
    endtask

    task automatic test_reset_mid_move();
        bit pulsed;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_chk++;
        if (shadow_state !== 2'd0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL pre_move_reset: got sh=%0d rdy=%b exp 0/1", shadow_state, cmd_ready); end
        cmd_valid = 1'b1; cmd_target = 2'd2; cmd_dwell = 4'd0;
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (shadow_state !== 2'd1 || busy !== 1'b1) begin n_err++; $display("FAIL mid_move: got sh=%0d busy=%b exp 1/1", shadow_state, busy); end
        #2 rst = 1'b1; #1;
        n_chk++;
        if ({i1, i2} !== 2'b00 || shadow_state !== 2'd0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got i=%b sh=%0d rdy=%b busy=%b done=%b exp 00/0/1/0/0", {i1, i2}, shadow_state, cmd_ready, busy, done);
        end
        @(negedge clk); rst = 1'b0;
        pulsed = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulsed = 1'b1;
        end
        n_chk++;
        if (pulsed || shadow_state !== 2'd0 || {i1, i2} !== 2'b00) begin
            n_err++; $display("FAIL post_reset_idle: got done_seen=%b sh=%0d i=%b exp 0/0/00", pulsed, shadow_state, {i1, i2});
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_target = 2'd0; cmd_dwell = 4'd0;
        chk_en = 1'b1; clr_mis = 1'b0; flt_o1 = 1'b0;
        cmd_valid_b = 1'b0; cmd_target_b = 2'd0; cmd_dwell_b = 4'd0;
        chk_en_b = 1'b1; clr_mis_b = 1'b0;
        o1_b = 1'b0; o2_b = 1'b0; err_b = 1'b0;
        test_reset();
        test_idle_to_s2();
        test_s2_to_er_busy();
        test_er_to_s1();
        test_same_target();
        test_fault_count();
        test_saturation();
        test_reset_mid_move();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
